// File: rtl/vector_buffer_file.sv
// vector_buffer_file: tile-granular activation scratchpad. Each buffer streams
// tiles through its own auto-incrementing read/write pointers; reads return one
// cycle after the pulse, and underrun / bad-id conditions are flagged as pulses.
module vector_buffer_file #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned TILE_ELEMS       = 32,
  parameter int unsigned NUM_BUFFERS      = 32,
  parameter int unsigned TILES_PER_BUFFER = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        rewind_enable,
  input  logic [4:0]                                  rewind_buffer_id,
  input  logic                                        vec_read_enable,
  input  logic [4:0]                                  vec_read_buffer_id,
  output logic signed [DATA_WIDTH*TILE_ELEMS-1:0]     vec_read_tile,
  output logic                                        vec_read_valid,
  input  logic                                        vec_write_enable,
  input  logic [4:0]                                  vec_write_buffer_id,
  input  logic signed [DATA_WIDTH*TILE_ELEMS-1:0]     vec_write_tile,
  output logic                                        err_underrun,
  output logic                                        err_bad_id
);

  localparam int unsigned TileW = DATA_WIDTH * TILE_ELEMS;
  localparam int unsigned PW    = (TILES_PER_BUFFER > 1) ? $clog2(TILES_PER_BUFFER) : 1;
  localparam int unsigned Depth = NUM_BUFFERS * TILES_PER_BUFFER;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [PW:0]   FillMax = (PW + 1)'(TILES_PER_BUFFER);
  localparam logic [PW-1:0] PtrLast = PW'(TILES_PER_BUFFER - 1);
  localparam logic [5:0]    NumBufs = 6'(NUM_BUFFERS);

  typedef enum logic [0:0] {StIdle, StResp} rd_state_e;

  logic [TileW-1:0] mem [Depth];

  logic [PW-1:0] rd_ptr_q [NUM_BUFFERS];
  logic [PW-1:0] rd_ptr_d [NUM_BUFFERS];
  logic [PW-1:0] wr_ptr_q [NUM_BUFFERS];
  logic [PW-1:0] wr_ptr_d [NUM_BUFFERS];
  logic [PW:0]   fill_q   [NUM_BUFFERS];
  logic [PW:0]   fill_d   [NUM_BUFFERS];

  rd_state_e state_q;

  logic          rd_id_ok, wr_id_ok, rw_id_ok;
  logic          rd_acc, wr_acc, rw_acc;
  logic          bad_any;
  logic [PW-1:0] rd_ptr_sel, wr_ptr_sel;
  logic [PW:0]   rd_fill_sel;
  logic [PW-1:0] rd_ptr_eff, wr_ptr_eff;
  logic [PW:0]   rd_fill_eff;
  logic          underrun;
  logic [AW-1:0] rd_addr, wr_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Command acceptance: out-of-range ids are dropped and only raise err_bad_id.
  always_comb begin
    rd_id_ok = ({1'b0, vec_read_buffer_id} < NumBufs);
    wr_id_ok = ({1'b0, vec_write_buffer_id} < NumBufs);
    rw_id_ok = ({1'b0, rewind_buffer_id} < NumBufs);
    rd_acc   = vec_read_enable & rd_id_ok;
    wr_acc   = vec_write_enable & wr_id_ok;
    rw_acc   = rewind_enable & rw_id_ok;
    bad_any  = (vec_read_enable & ~rd_id_ok) | (vec_write_enable & ~wr_id_ok) |
               (rewind_enable & ~rw_id_ok);
  end

  // Select the addressed buffer's pointers; a same-cycle rewind is seen first.
  always_comb begin
    rd_ptr_sel  = '0;
    rd_fill_sel = '0;
    wr_ptr_sel  = '0;
    for (int unsigned b = 0; b < NUM_BUFFERS; b++) begin
      if (vec_read_buffer_id == 5'(b)) begin
        rd_ptr_sel  = rd_ptr_q[b];
        rd_fill_sel = fill_q[b];
      end
      if (vec_write_buffer_id == 5'(b)) begin
        wr_ptr_sel = wr_ptr_q[b];
      end
    end
    if (rw_acc && (rewind_buffer_id == vec_read_buffer_id)) begin
      rd_ptr_eff  = '0;
      rd_fill_eff = '0;
    end else begin
      rd_ptr_eff  = rd_ptr_sel;
      rd_fill_eff = rd_fill_sel;
    end
    if (rw_acc && (rewind_buffer_id == vec_write_buffer_id)) begin
      wr_ptr_eff = '0;
    end else begin
      wr_ptr_eff = wr_ptr_sel;
    end
    underrun = ({1'b0, rd_ptr_eff} >= rd_fill_eff);
    rd_addr  = AW'(vec_read_buffer_id) * AW'(TILES_PER_BUFFER) + AW'(rd_ptr_eff);
    wr_addr  = AW'(vec_write_buffer_id) * AW'(TILES_PER_BUFFER) + AW'(wr_ptr_eff);
  end

  // Per-buffer pointer/fill next state: rewind, then write, then read advance.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BUFFERS; b++) begin
      rd_ptr_d[b] = rd_ptr_q[b];
      wr_ptr_d[b] = wr_ptr_q[b];
      fill_d[b]   = fill_q[b];
      if (rw_acc && (rewind_buffer_id == 5'(b))) begin
        rd_ptr_d[b] = '0;
        wr_ptr_d[b] = '0;
        fill_d[b]   = '0;
      end
      if (wr_acc && (vec_write_buffer_id == 5'(b))) begin
        wr_ptr_d[b] = ptr_inc(wr_ptr_d[b]);
        fill_d[b]   = (fill_d[b] == FillMax) ? FillMax : fill_d[b] + 1'b1;
      end
      if (rd_acc && (vec_read_buffer_id == 5'(b))) begin
        rd_ptr_d[b] = ptr_inc(rd_ptr_d[b]);
      end
    end
  end

  // Pointer and fill registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_BUFFERS; b++) begin
        rd_ptr_q[b] <= '0;
        wr_ptr_q[b] <= '0;
        fill_q[b]   <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BUFFERS; b++) begin
        rd_ptr_q[b] <= rd_ptr_d[b];
        wr_ptr_q[b] <= wr_ptr_d[b];
        fill_q[b]   <= fill_d[b];
      end
    end
  end

  // Tile storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr] <= vec_write_tile;
    end
  end

  // Registered read data; nonblocking read gives read-first on a slot collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_read_tile <= '0;
    end else if (rd_acc) begin
      vec_read_tile <= mem[rd_addr];
    end
  end

  // Read-response FSM with registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      err_underrun <= 1'b0;
      err_bad_id   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= rd_acc ? StResp : StIdle;
        StResp:  state_q <= rd_acc ? StResp : StIdle;
        default: state_q <= StIdle;
      endcase
      err_underrun <= rd_acc & underrun;
      err_bad_id   <= bad_any;
    end
  end

  assign vec_read_valid = (state_q == StResp);

endmodule

// File: tb/tb_vector_buffer_file.sv
// Directed bench for vector_buffer_file: a table of one-cycle command rows with
// expected registered outputs, plus wrap and mid-stream reset sequences.
module tb_vector_buffer_file;

  localparam int unsigned DW = 8;
  localparam int unsigned TE = 32;
  localparam int unsigned NB = 24;  // below 32 so the 5-bit id field has invalid values
  localparam int unsigned TP = 32;
  localparam int unsigned TW = DW * TE;
  localparam int unsigned NV = 33;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rewind_enable = 1'b0;
  logic [4:0]           rewind_buffer_id = '0;
  logic                 vec_read_enable = 1'b0;
  logic [4:0]           vec_read_buffer_id = '0;
  logic signed [TW-1:0] vec_read_tile;
  logic                 vec_read_valid;
  logic                 vec_write_enable = 1'b0;
  logic [4:0]           vec_write_buffer_id = '0;
  logic signed [TW-1:0] vec_write_tile = '0;
  logic                 err_underrun;
  logic                 err_bad_id;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       rw;
    logic [4:0] rw_id;
    logic       rd;
    logic [4:0] rd_id;
    logic       wr;
    logic [4:0] wr_id;
    int         wr_base;
    logic       e_valid;
    int         e_base;
    logic       e_under;
    logic       e_bad;
  } vec_t;

  vec_t vecs [NV];

  vector_buffer_file #(
    .DATA_WIDTH(DW),
    .TILE_ELEMS(TE),
    .NUM_BUFFERS(NB),
    .TILES_PER_BUFFER(TP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rewind_enable(rewind_enable),
    .rewind_buffer_id(rewind_buffer_id),
    .vec_read_enable(vec_read_enable),
    .vec_read_buffer_id(vec_read_buffer_id),
    .vec_read_tile(vec_read_tile),
    .vec_read_valid(vec_read_valid),
    .vec_write_enable(vec_write_enable),
    .vec_write_buffer_id(vec_write_buffer_id),
    .vec_write_tile(vec_write_tile),
    .err_underrun(err_underrun),
    .err_bad_id(err_bad_id)
  );

  always #5 clk = ~clk;

  // Tile whose element i is base+i, truncated to DW bits.
  function automatic logic [TW-1:0] tile_of(input int base);
    logic [TW-1:0] t;
    for (int i = 0; i < int'(TE); i++) t[i*DW +: DW] = DW'(base + i);
    return t;
  endfunction

  function automatic vec_t mk(input logic rw, input int rw_id, input logic rd, input int rd_id,
                              input logic wr, input int wr_id, input int wr_base,
                              input logic e_valid, input int e_base, input logic e_under,
                              input logic e_bad);
    vec_t v;
    v.rw = rw;       v.rw_id = 5'(rw_id);
    v.rd = rd;       v.rd_id = 5'(rd_id);
    v.wr = wr;       v.wr_id = 5'(wr_id);
    v.wr_base = wr_base;
    v.e_valid = e_valid; v.e_base = e_base; v.e_under = e_under; v.e_bad = e_bad;
    return v;
  endfunction

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rewind_enable    = 1'b0;
    vec_read_enable  = 1'b0;
    vec_write_enable = 1'b0;
  endtask

  task automatic do_read(input int id);
    idle_inputs();
    vec_read_enable    = 1'b1;
    vec_read_buffer_id = 5'(id);
    tick();
  endtask

  task automatic do_write(input int id, input int base);
    idle_inputs();
    vec_write_enable    = 1'b1;
    vec_write_buffer_id = 5'(id);
    vec_write_tile      = tile_of(base);
    tick();
  endtask

  task automatic do_rewind(input int id);
    idle_inputs();
    rewind_enable    = 1'b1;
    rewind_buffer_id = 5'(id);
    tick();
  endtask

  initial begin
    //             rw id  rd id  wr id base  valid base under bad
    vecs[0]  = mk(1, 3, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    for (int k = 0; k < 4; k++) vecs[1+k] = mk(0, 0, 0, 0, 1, 3, k*4-64, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) vecs[5+k] = mk(0, 0, 1, 3, 0, 0, 0, 1, k*4-64, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[10] = mk(1, 5, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 5, 100,  0, 0,   0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 5, 110,  0, 0,   0, 0);
    vecs[13] = mk(1, 5, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 5, 7,    0, 0,   0, 0);
    vecs[15] = mk(0, 0, 1, 5, 0, 0, 0,    1, 7,   0, 0);
    vecs[16] = mk(0, 0, 1, 5, 0, 0, 0,    1, 110, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[18] = mk(1, 2, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[19] = mk(0, 0, 0, 0, 1, 2, 20,   0, 0,   0, 0);
    vecs[20] = mk(1, 2, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[21] = mk(0, 0, 1, 2, 1, 2, 40,   1, 20,  1, 0);
    vecs[22] = mk(1, 2, 1, 2, 0, 0, 0,    1, 40,  1, 0);
    vecs[23] = mk(1, 2, 1, 2, 1, 2, 60,   1, 40,  1, 0);
    vecs[24] = mk(0, 0, 0, 0, 1, 2, 80,   0, 0,   0, 0);
    vecs[25] = mk(0, 0, 1, 2, 0, 0, 0,    1, 80,  0, 0);
    vecs[26] = mk(1, 2, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[27] = mk(0, 0, 1, 2, 0, 0, 0,    1, 60,  1, 0);
    vecs[28] = mk(0, 0, 1, 28, 0, 0, 0,   0, 0,   0, 1);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0,   0, 0);
    vecs[30] = mk(1, 30, 1, 31, 1, 28, 5, 0, 0,   0, 1);
    vecs[31] = mk(0, 0, 1, 2, 0, 0, 0,    1, 80,  1, 0);
    vecs[32] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0,   0, 0);

    // Reset state.
    tick();
    tick();
    check("reset valid", TW'(vec_read_valid), '0);
    check("reset underrun", TW'(err_underrun), '0);
    check("reset bad_id", TW'(err_bad_id), '0);
    check("reset tile", vec_read_tile, '0);
    rst = 1'b0;
    tick();

    // Table-driven rows: one command cycle each, outputs checked after the edge.
    for (int i = 0; i < int'(NV); i++) begin
      rewind_enable       = vecs[i].rw;
      rewind_buffer_id    = vecs[i].rw_id;
      vec_read_enable     = vecs[i].rd;
      vec_read_buffer_id  = vecs[i].rd_id;
      vec_write_enable    = vecs[i].wr;
      vec_write_buffer_id = vecs[i].wr_id;
      vec_write_tile      = tile_of(vecs[i].wr_base);
      tick();
      check($sformatf("row%0d valid", i), TW'(vec_read_valid), TW'(vecs[i].e_valid));
      check($sformatf("row%0d underrun", i), TW'(err_underrun), TW'(vecs[i].e_under));
      check($sformatf("row%0d bad_id", i), TW'(err_bad_id), TW'(vecs[i].e_bad));
      if (vecs[i].e_valid)
        check($sformatf("row%0d tile", i), vec_read_tile, tile_of(vecs[i].e_base));
    end
    idle_inputs();

    // Wrap: 33 writes to buffer 0, slot 0 ends up holding the 33rd tile.
    do_rewind(0);
    for (int j = 0; j < 33; j++) do_write(0, j * 3);
    for (int k = 0; k < 33; k++) begin
      do_read(0);
      check($sformatf("wrap%0d valid", k), TW'(vec_read_valid), TW'(1));
      check($sformatf("wrap%0d underrun", k), TW'(err_underrun), '0);
      check($sformatf("wrap%0d tile", k), vec_read_tile,
            tile_of(((k % 32) == 0) ? 96 : (k % 32) * 3));
    end
    idle_inputs();
    tick();
    check("wrap idle valid", TW'(vec_read_valid), '0);

    // Reset during the response cycle of a read.
    do_read(0);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("midrst valid", TW'(vec_read_valid), '0);
    check("midrst tile", vec_read_tile, '0);
    tick();
    check("midrst valid held", TW'(vec_read_valid), '0);
    rst = 1'b0;
    do_read(0);
    check("postrst b0 valid", TW'(vec_read_valid), TW'(1));
    check("postrst b0 tile", vec_read_tile, tile_of(96));
    check("postrst b0 underrun", TW'(err_underrun), TW'(1));
    do_read(3);
    check("postrst b3 tile", vec_read_tile, tile_of(-64));
    check("postrst b3 underrun", TW'(err_underrun), TW'(1));
    idle_inputs();
    tick();
    check("postrst idle valid", TW'(vec_read_valid), '0);
    check("postrst idle tile held", vec_read_tile, tile_of(-64));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
